// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse receiver:
//   - letter codes A..Z = 0..25
//   - element encoding (dot = 0, dash = 1) and element pattern/length types
//   - receiver state enum
//   - decode_letter(): (len, pat) -> {ok, code}
// Patterns are built by shifting each new element into the LSB, so the first
// element of a letter ends up in the highest used bit and unused upper bits
// are zero.
// ---------------------------------------------------------------------------
package morse_pkg;

    localparam logic [4:0] LTR_A = 5'd0,  LTR_B = 5'd1,  LTR_C = 5'd2,  LTR_D = 5'd3,
                           LTR_E = 5'd4,  LTR_F = 5'd5,  LTR_G = 5'd6,  LTR_H = 5'd7,
                           LTR_I = 5'd8,  LTR_J = 5'd9,  LTR_K = 5'd10, LTR_L = 5'd11,
                           LTR_M = 5'd12, LTR_N = 5'd13, LTR_O = 5'd14, LTR_P = 5'd15,
                           LTR_Q = 5'd16, LTR_R = 5'd17, LTR_S = 5'd18, LTR_T = 5'd19,
                           LTR_U = 5'd20, LTR_V = 5'd21, LTR_W = 5'd22, LTR_X = 5'd23,
                           LTR_Y = 5'd24, LTR_Z = 5'd25;

    localparam logic EL_DOT  = 1'b0;
    localparam logic EL_DASH = 1'b1;

    localparam int unsigned MAX_ELEMENTS = 4;

    typedef logic [2:0] el_len_t;
    typedef logic [3:0] el_pat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_DISCARD
    } rx_state_e;

    typedef struct packed {
        logic       ok;
        logic [4:0] code;
    } decode_t;

    function automatic decode_t decode_letter(input el_len_t len, input el_pat_t pat);
        decode_t r;
        r.ok   = 1'b1;
        r.code = '0;
        case ({len, pat})
            {3'd1, 4'b0000}: r.code = LTR_E;
            {3'd1, 4'b0001}: r.code = LTR_T;
            {3'd2, 4'b0000}: r.code = LTR_I;
            {3'd2, 4'b0001}: r.code = LTR_A;
            {3'd2, 4'b0010}: r.code = LTR_N;
            {3'd2, 4'b0011}: r.code = LTR_M;
            {3'd3, 4'b0000}: r.code = LTR_S;
            {3'd3, 4'b0001}: r.code = LTR_U;
            {3'd3, 4'b0010}: r.code = LTR_R;
            {3'd3, 4'b0011}: r.code = LTR_W;
            {3'd3, 4'b0100}: r.code = LTR_D;
            {3'd3, 4'b0101}: r.code = LTR_K;
            {3'd3, 4'b0110}: r.code = LTR_G;
            {3'd3, 4'b0111}: r.code = LTR_O;
            {3'd4, 4'b0000}: r.code = LTR_H;
            {3'd4, 4'b0001}: r.code = LTR_V;
            {3'd4, 4'b0010}: r.code = LTR_F;
            {3'd4, 4'b0100}: r.code = LTR_L;
            {3'd4, 4'b0110}: r.code = LTR_P;
            {3'd4, 4'b0111}: r.code = LTR_J;
            {3'd4, 4'b1000}: r.code = LTR_B;
            {3'd4, 4'b1001}: r.code = LTR_X;
            {3'd4, 4'b1010}: r.code = LTR_C;
            {3'd4, 4'b1011}: r.code = LTR_Y;
            {3'd4, 4'b1100}: r.code = LTR_Z;
            {3'd4, 4'b1101}: r.code = LTR_Q;
            default:         r.ok   = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// ---------------------------------------------------------------------------
// morse_unit_tick
// Down-counting divider that produces a one-cycle tick once per Morse unit.
// The first tick comes UNIT_CYCLES cycles after reset release.
// Ports:
//   clock   - system clock
//   reset_n - synchronous, active-low reset (loads UNIT_CYCLES-1)
//   tick    - high for one cycle every UNIT_CYCLES cycles
// ---------------------------------------------------------------------------
module morse_unit_tick #(
    parameter int unsigned UNIT_CYCLES = 25000000
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned       CNT_W  = $clog2(UNIT_CYCLES);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign tick = (r_count == '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= RELOAD;
        end else if (tick) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/morse_receiver.sv
// ---------------------------------------------------------------------------
// morse_receiver
// Samples a serial Morse line once per unit, measures mark/space run lengths,
// classifies marks as dot (1..2 units) or dash (>=3 units), assembles up to
// four elements and decodes them to a 5-bit letter code (A=0 .. Z=25).
// Ports:
//   clock        - system clock
//   reset_n      - synchronous, active-low reset
//   line_in      - serial Morse line, 1 = mark (2-FF synchronised)
//   letter       - last decoded letter code, held until the next decode
//   letter_valid - one-cycle pulse, letter valid this cycle
//   error        - one-cycle pulse on malformed input
//   word_gap     - one-cycle pulse on an inter-word gap
// Optional build macro MORSE_RX_WORD_GAP_EN enables word_gap detection; when
// undefined word_gap is tied to 0 and no gap counter exists.
// ---------------------------------------------------------------------------
module morse_receiver #(
    parameter int unsigned UNIT_CYCLES = 25000000,
    parameter int unsigned MAX_MARK    = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       line_in,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic       error,
    output logic       word_gap
);

    import morse_pkg::*;

    localparam int unsigned       RUN_W    = $clog2(MAX_MARK + 1);
    localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0]  RUN_TWO  = RUN_W'(2);
    localparam logic [RUN_W-1:0]  RUN_DASH = RUN_W'(3);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MAX_MARK);

    logic             w_tick;
    logic             w_s;
    decode_t          w_dec;

    logic             r_sync1;
    logic             r_sync2;
    rx_state_e        r_state;
    logic [RUN_W-1:0] r_run;
    el_pat_t          r_pat;
    el_len_t          r_len;
    logic [1:0]       r_zeros;
    logic [4:0]       r_letter;
    logic             r_letter_valid;
    logic             r_error;

`ifdef MORSE_RX_WORD_GAP_EN
    logic             r_word_gap;
    logic             r_gap_armed;
    logic [2:0]       r_gap;
`endif

    morse_unit_tick #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (w_tick)
    );

    assign w_s   = r_sync2;
    assign w_dec = decode_letter(r_len, r_pat);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= line_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_run          <= '0;
            r_pat          <= '0;
            r_len          <= '0;
            r_zeros        <= '0;
            r_letter       <= '0;
            r_letter_valid <= 1'b0;
            r_error        <= 1'b0;
`ifdef MORSE_RX_WORD_GAP_EN
            r_word_gap     <= 1'b0;
            r_gap_armed    <= 1'b0;
            r_gap          <= '0;
`endif
        end else begin
            r_letter_valid <= 1'b0;
            r_error        <= 1'b0;
`ifdef MORSE_RX_WORD_GAP_EN
            r_word_gap     <= 1'b0;
`endif
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_s) begin
                            r_state <= ST_MARK;
                            r_run   <= RUN_ONE;
                            r_pat   <= '0;
                            r_len   <= '0;
`ifdef MORSE_RX_WORD_GAP_EN
                            r_gap_armed <= 1'b0;
                            r_gap       <= '0;
`endif
                        end
`ifdef MORSE_RX_WORD_GAP_EN
                        // Gap count continues from the 3 units already seen in SPACE.
                        else if (r_gap_armed) begin
                            if (r_gap == 3'd6) begin
                                r_word_gap  <= 1'b1;
                                r_gap_armed <= 1'b0;
                            end
                            r_gap <= r_gap + 1'b1;
                        end
`endif
                    end
                    ST_MARK: begin
                        if (w_s) begin
                            if (r_run == RUN_MAX) begin
                                r_error <= 1'b1;
                                r_state <= ST_DISCARD;
                                r_zeros <= '0;
                            end else begin
                                r_run <= r_run + 1'b1;
                            end
                        end else if (r_len == el_len_t'(MAX_ELEMENTS)) begin
                            r_error <= 1'b1;
                            r_state <= ST_DISCARD;
                            r_zeros <= '0;
                        end else begin
                            r_pat   <= {r_pat[2:0], (r_run >= RUN_DASH) ? EL_DASH : EL_DOT};
                            r_len   <= r_len + 1'b1;
                            r_state <= ST_SPACE;
                            r_run   <= RUN_ONE;
                        end
                    end
                    ST_SPACE: begin
                        if (w_s) begin
                            r_state <= ST_MARK;
                            r_run   <= RUN_ONE;
                        end else if (r_run == RUN_TWO) begin
                            // Third consecutive space unit ends the letter.
                            if (w_dec.ok) begin
                                r_letter       <= w_dec.code;
                                r_letter_valid <= 1'b1;
`ifdef MORSE_RX_WORD_GAP_EN
                                r_gap_armed    <= 1'b1;
                                r_gap          <= 3'd3;
`endif
                            end else begin
                                r_error <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end else begin
                            r_run <= r_run + 1'b1;
                        end
                    end
                    ST_DISCARD: begin
                        if (w_s) begin
                            r_zeros <= '0;
                        end else if (r_zeros == 2'd2) begin
                            r_zeros <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_zeros <= r_zeros + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign letter       = r_letter;
    assign letter_valid = r_letter_valid;
    assign error        = r_error;

`ifdef MORSE_RX_WORD_GAP_EN
    assign word_gap = r_word_gap;
`else
    assign word_gap = 1'b0;
`endif

endmodule

// File: tb/tb_morse_receiver.sv
// ---------------------------------------------------------------------------
// tb_morse_receiver
// Directed bench for morse_receiver with UNIT_CYCLES=4. Each stimulus string
// gives one line sample per unit; the expected tick indices of letter_valid,
// error and word_gap pulses are given alongside. Line changes are placed just
// after each tick edge so the synchronised sample is stable at the next tick.
// Honours MORSE_RX_WORD_GAP_EN for the word_gap expectations.
// ---------------------------------------------------------------------------
module tb_morse_receiver;

    localparam int unsigned UNIT = 4;

`ifdef MORSE_RX_WORD_GAP_EN
    localparam int WG_AT    = 3;
    localparam int WG_TOTAL = 1;
`else
    localparam int WG_AT    = -1;
    localparam int WG_TOTAL = 0;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       line_in = 1'b0;
    logic [4:0] letter;
    logic       letter_valid;
    logic       error;
    logic       word_gap;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         n_valid_hi = 0;
    int         n_err_hi   = 0;
    int         n_wg_hi    = 0;
    logic [4:0] exp_letter = '0;

    always #5 clock = ~clock;

    morse_receiver #(
        .UNIT_CYCLES(UNIT),
        .MAX_MARK   (7)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .line_in     (line_in),
        .letter      (letter),
        .letter_valid(letter_valid),
        .error       (error),
        .word_gap    (word_gap)
    );

    // Counting high cycles makes any pulse longer than one cycle show up in the totals.
    always @(negedge clock) begin
        if (letter_valid === 1'b1) n_valid_hi++;
        if (error === 1'b1)        n_err_hi++;
        if (word_gap === 1'b1)     n_wg_hi++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        line_in = 1'b0;
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
        reset_n = 1'b1;
    endtask

    task automatic play(input string name, input string pat, input int v_at,
                        input logic [4:0] v_code, input int e_at, input int w_at);
        for (int i = 0; i < pat.len(); i++) begin
            line_in = (pat[i] == "1");
            repeat (UNIT) begin
                @(posedge clock);
                #1;
            end
            if (i == v_at) exp_letter = v_code;
            check_val($sformatf("%s[%0d] letter_valid", name, i), 32'(letter_valid), 32'(i == v_at));
            check_val($sformatf("%s[%0d] error", name, i),        32'(error),        32'(i == e_at));
            check_val($sformatf("%s[%0d] word_gap", name, i),     32'(word_gap),     32'(i == w_at));
            check_val($sformatf("%s[%0d] letter", name, i),       32'(letter),       32'(exp_letter));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        apply_reset(3);
        check_val("reset letter",       32'(letter),       32'd0);
        check_val("reset letter_valid", 32'(letter_valid), 32'd0);
        check_val("reset error",        32'(error),        32'd0);
        check_val("reset word_gap",     32'(word_gap),     32'd0);

        play("A",     "10111000",         7,  5'd0,  -1, -1);
        play("E",     "1000",             3,  5'd4,  -1, -1);
        play("T",     "111000",           5,  5'd19, -1, -1);
        play("S",     "10101000",         7,  5'd18, -1, -1);
        play("Q",     "1110111010111000", 15, 5'd16, -1, -1);
        play("dots5", "1010101010000",    -1, 5'd0,  9,  -1);
        play("E2",    "1000",             3,  5'd4,  -1, -1);
        play("ddDD",  "10101110111000",   -1, 5'd0,  13, -1);
        play("mark8", "11111111111000",   -1, 5'd0,  7,  -1);
        play("T2",    "111000",           5,  5'd19, -1, -1);

        play("Chead", "1110",             -1, 5'd0,  -1, -1);
        apply_reset(2);
        exp_letter = '0;
        check_val("midreset letter",       32'(letter),       32'd0);
        check_val("midreset letter_valid", 32'(letter_valid), 32'd0);
        check_val("midreset error",        32'(error),        32'd0);
        play("I",     "101000",           5,  5'd8,  -1, -1);
        play("gap",   "0000000",          -1, 5'd0,  -1, WG_AT);

        check_val("total letter_valid cycles", 32'(n_valid_hi), 32'd8);
        check_val("total error cycles",        32'(n_err_hi),   32'd3);
        check_val("total word_gap cycles",     32'(n_wg_hi),    32'(WG_TOTAL));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
